// File: rtl/decrypt_pkg.sv
// Shared definitions for the LFSR cipher: encryptor FSM states, sizing constants
// and the LFSR step function used identically by both ends of the link.
package decrypt_pkg;
  localparam int MSG_LEN = 64;
  localparam int LFSR_W  = 5;

  typedef enum logic [2:0] {
    ENC_IDLE,
    ENC_PRE,
    ENC_FILL,
    ENC_MSG,
    ENC_DONE
  } enc_state_t;

  // Shift left, feedback = parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                  input logic [LFSR_W-1:0] taps);
    return {state[LFSR_W-2:0], ^(state & taps)};
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// Keystream register: load a seed, advance one step on request, otherwise hold.
module lfsr_core #(
  parameter int LFSR_W = decrypt_pkg::LFSR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic [LFSR_W-1:0] taps_i,
  output logic [LFSR_W-1:0] state_o
);
  import decrypt_pkg::*;

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = lfsr_next(state_q, taps_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/lfsr_encrypt.sv
// Encryptor: writes pre_len preamble bytes then plaintext, each XORed with the
// current LFSR state, to a MSG_LEN-byte ciphertext buffer.
module lfsr_encrypt #(
  parameter int MSG_LEN = decrypt_pkg::MSG_LEN,
  parameter int LFSR_W  = decrypt_pkg::LFSR_W,
  parameter int ADDR_W  = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] start,
  input  logic [3:0]        pre_len,
  input  logic [7:0]        preamble,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done
);
  import decrypt_pkg::*;

  enc_state_t        state_q;
  logic              init_q;
  logic [LFSR_W-1:0] taps_q;
  logic [3:0]        pre_len_q;
  logic [7:0]        preamble_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              done_q;

  logic              step_d;
  logic [7:0]        src_d;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        key_byte;

  // The LFSR advances exactly on the cycles that register a write.
  always_comb begin
    step_d = 1'b0;
    src_d  = preamble_q;
    if (!init) begin
      case (state_q)
        ENC_PRE: step_d = 1'b1;
        ENC_MSG: begin
          step_d = 1'b1;
          src_d  = rd_data;
        end
        default: ;
      endcase
    end
  end

  assign key_byte = {{(8-LFSR_W){1'b0}}, lfsr};

  lfsr_core #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (init),
    .step_i (step_d),
    .seed_i (start),
    .taps_i (taps_q),
    .state_o(lfsr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ENC_IDLE;
      init_q     <= 1'b0;
      taps_q     <= '0;
      pre_len_q  <= '0;
      preamble_q <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      init_q  <= init;
      wr_en_q <= 1'b0;
      if (init) begin
        taps_q     <= taps;
        pre_len_q  <= pre_len;
        preamble_q <= preamble;
        done_q     <= 1'b0;
        cnt_q      <= '0;
        rd_addr_q  <= '0;
        state_q    <= ENC_IDLE;
      end else begin
        case (state_q)
          ENC_IDLE: begin
            if (init_q) begin
              cnt_q   <= '0;
              state_q <= (pre_len_q == 4'd0) ? ENC_FILL : ENC_PRE;
            end
          end
          ENC_PRE: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= src_d ^ key_byte;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q + 1'b1 == ADDR_W'(pre_len_q)) begin
              state_q <= ENC_FILL;
            end
          end
          ENC_FILL: begin
            // Address 0 has been on the bus since init; move on to 1.
            rd_addr_q <= rd_addr_q + 1'b1;
            state_q   <= ENC_MSG;
          end
          ENC_MSG: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= src_d ^ key_byte;
            cnt_q     <= cnt_q + 1'b1;
            // Stop the read pointer on the last plaintext byte actually needed.
            if (cnt_q < ADDR_W'(MSG_LEN-2)) begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
            if (cnt_q == ADDR_W'(MSG_LEN-1)) begin
              state_q <= ENC_DONE;
            end
          end
          ENC_DONE: done_q <= 1'b1;
          default:  state_q <= ENC_IDLE;
        endcase
      end
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
endmodule
